// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_pkg
// Description : Shared types and helpers for the banked RAM controller:
//               controller state encoding and the depth-from-address helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_pkg;

  // Controller states: serving port A requests, or filling the array.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Number of words addressed by an address of the given width.
  function automatic int unsigned depth_of(input int unsigned addr_bits);
    return 32'd1 << addr_bits;
  endfunction

endpackage : ram_pkg
`default_nettype wire

// File: rtl/ram_array.sv
`default_nettype none
// ============================================================================
// Module      : ram_array
// Description : Word storage with one synchronous write/read port (A) and
//               one synchronous read-only port (B). Both reads are read-first:
//               a write on the same edge is seen only by the next read.
//               The storage itself is never reset; only the read registers are.
// Ports       : clk, reset (async, active-low)
//               i_we_a/i_re_a    - port A write / read strobes
//               i_addr_a         - port A address
//               i_wdata_a        - port A write data
//               o_rdata_a        - port A read register (held between reads)
//               i_addr_b         - port B read address (read every cycle)
//               o_rdata_b        - port B read register
// Revision    : 1.0 - initial release
// ============================================================================
module ram_array
  import ram_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned ADDR_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_we_a,
  input  logic                 i_re_a,
  input  logic [ADDR_BITS-1:0] i_addr_a,
  input  logic [DATA_BITS-1:0] i_wdata_a,
  output logic [DATA_BITS-1:0] o_rdata_a,
  input  logic [ADDR_BITS-1:0] i_addr_b,
  output logic [DATA_BITS-1:0] o_rdata_b
);

  localparam int unsigned DEPTH = depth_of(ADDR_BITS);

  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [DATA_BITS-1:0] r_rdata_a;
  logic [DATA_BITS-1:0] r_rdata_b;

  // No reset on the array so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (i_we_a) begin
      r_mem[i_addr_a] <= i_wdata_a;
    end
  end

  // Non-blocking reads of r_mem sample the pre-write contents (read-first).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata_a <= '0;
      r_rdata_b <= '0;
    end else begin
      if (i_re_a) begin
        r_rdata_a <= r_mem[i_addr_a];
      end
      r_rdata_b <= r_mem[i_addr_b];
    end
  end

  assign o_rdata_a = r_rdata_a;
  assign o_rdata_b = r_rdata_b;

endmodule : ram_array
`default_nettype wire

// File: rtl/banked_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : banked_ram_ctrl
// Description : Synchronous RAM with a req/ready handshake on port A,
//               registered read data with a one-cycle valid strobe, a
//               hardware clear sequencer and a read-only scan-out port B.
// Ports       : clk, reset (async, active-low)
//               i_req, i_we, i_address, i_data_in  - port A request
//               o_ready                            - port A can accept
//               o_data_out, o_data_valid           - port A read result
//               i_clear, o_busy                    - clear start / running
//               i_addr_b, o_data_out_b             - port B read
// Revision    : 1.0 - initial release
// ============================================================================
module banked_ram_ctrl
  import ram_pkg::*;
#(
  parameter int unsigned          DATA_BITS      = 8,
  parameter int unsigned          ADDR_BITS      = 16,
  parameter logic [DATA_BITS-1:0] CLEAR_VALUE    = '0,
  parameter bit                   CLEAR_ON_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_req,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_address,
  input  logic [DATA_BITS-1:0] i_data_in,
  output logic                 o_ready,
  output logic [DATA_BITS-1:0] o_data_out,
  output logic                 o_data_valid,
  input  logic                 i_clear,
  output logic                 o_busy,
  input  logic [ADDR_BITS-1:0] i_addr_b,
  output logic [DATA_BITS-1:0] o_data_out_b
);

  state_t               r_state;
  state_t               w_next;
  logic [ADDR_BITS-1:0] r_cnt;
  logic                 r_valid;
  logic                 w_ready;
  logic                 w_busy;
  logic                 w_accept;
  logic                 w_re;
  logic                 w_we;
  logic [ADDR_BITS-1:0] w_addr;
  logic [DATA_BITS-1:0] w_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      // Counter wraps to 0 naturally after the last address.
      if (r_state == ST_CLEAR) begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_valid <= w_re;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_busy  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (i_clear) begin
          w_next = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        w_busy = 1'b1;
        if (r_cnt == '1) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // ready is forced low while reset is held, even when the reset state is IDLE.
  assign o_ready  = w_ready & reset;
  assign o_busy   = w_busy;

  // clear wins over a same-cycle request; the requester must hold req.
  assign w_accept = i_req & o_ready & ~i_clear;
  assign w_re     = w_accept & ~i_we;
  // Gate with reset so a held reset in CLEAR does not keep writing address 0.
  assign w_we     = reset & (w_busy | (w_accept & i_we));
  assign w_addr   = w_busy ? r_cnt       : i_address;
  assign w_wdata  = w_busy ? CLEAR_VALUE : i_data_in;

  ram_array #(
    .DATA_BITS (DATA_BITS),
    .ADDR_BITS (ADDR_BITS)
  ) u_array (
    .clk       (clk),
    .reset     (reset),
    .i_we_a    (w_we),
    .i_re_a    (w_re),
    .i_addr_a  (w_addr),
    .i_wdata_a (w_wdata),
    .o_rdata_a (o_data_out),
    .i_addr_b  (i_addr_b),
    .o_rdata_b (o_data_out_b)
  );

  assign o_data_valid = r_valid;

endmodule : banked_ram_ctrl
`default_nettype wire
